// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Fifth and final pipeline stage. It selects the write-back source
//            (ALU / load data / PC+4 / upper immediate), extracts and extends
//            load data, and drives the register-file write port. The stage
//            stalls upstream while load data is outstanding and reports load
//            timeouts and misaligned loads.
// Ports    : clock, reset                 - clock, synchronous active-high reset
//            instr_valid_ip, wb_mux_ip,
//            wb_alu_result_ip/_valid_ip,
//            write_reg_addr_ip, pc_addr_ip,
//            uimmd_ip                     - memory-stage pipeline buffer
//            lsu_operator_ip,
//            load_byte_offset_ip,
//            load_data_ip/_valid_ip       - load type, lane and raw load word
//            rf_we_op, rf_waddr_op,
//            rf_wdata_op                  - register-file write port
//            stall_op                     - upstream hold request
//            load_timeout_op              - sticky load-abort flag
//            misalign_op                  - pulse on a dropped misaligned load
//            retired_count_op             - completed-instruction counter
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid_ip,
    input  logic [1:0]       wb_mux_ip,
    input  logic [31:0]      wb_alu_result_ip,
    input  logic             wb_alu_result_valid_ip,
    input  logic [4:0]       write_reg_addr_ip,
    input  logic [31:0]      pc_addr_ip,
    input  logic [31:0]      uimmd_ip,
    input  logic [2:0]       lsu_operator_ip,
    input  logic [1:0]       load_byte_offset_ip,
    input  logic [31:0]      load_data_ip,
    input  logic             load_data_valid_ip,
    output logic             rf_we_op,
    output logic [4:0]       rf_waddr_op,
    output logic [31:0]      rf_wdata_op,
    output logic             stall_op,
    output logic             load_timeout_op,
    output logic             misalign_op,
    output logic [CNT_W-1:0] retired_count_op
);

    localparam logic [1:0] C_MUX_ALU   = 2'd0;
    localparam logic [1:0] C_MUX_LSU   = 2'd1;
    localparam logic [1:0] C_MUX_PC4   = 2'd2;
    localparam logic [1:0] C_MUX_UIMMD = 2'd3;

    localparam logic [2:0] C_OP_LB  = 3'd0;
    localparam logic [2:0] C_OP_LH  = 3'd1;
    localparam logic [2:0] C_OP_LW  = 3'd2;
    localparam logic [2:0] C_OP_LBU = 3'd4;
    localparam logic [2:0] C_OP_LHU = 3'd5;

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_WAIT = 1'b1;

    // Last counter value before the wait is abandoned.
    localparam logic [7:0]       C_TO_LAST  = 8'(LOAD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Shift the addressed lane down to bit 0, then extend per load type.
    function automatic logic [31:0] extract_load(input logic [2:0]  op,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (op)
            C_OP_LB:  extract_load = {{24{sh[7]}}, sh[7:0]};
            C_OP_LH:  extract_load = {{16{sh[15]}}, sh[15:0]};
            C_OP_LBU: extract_load = {24'd0, sh[7:0]};
            C_OP_LHU: extract_load = {16'd0, sh[15:0]};
            default:  extract_load = word;
        endcase
    endfunction

    // Illegal operators are treated as misaligned so they are dropped too.
    function automatic logic is_misaligned(input logic [2:0] op,
                                           input logic [1:0] off);
        case (op)
            C_OP_LB, C_OP_LBU: is_misaligned = 1'b0;
            C_OP_LH, C_OP_LHU: is_misaligned = off[0];
            C_OP_LW:           is_misaligned = (off != 2'd0);
            default:           is_misaligned = 1'b1;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]       state_q,    state_d;
    logic [7:0]       cnt_q,      cnt_d;
    logic [4:0]       pend_rd_q,  pend_rd_d;
    logic [2:0]       pend_op_q,  pend_op_d;
    logic [1:0]       pend_off_q, pend_off_d;
    logic             we_q,       we_d;
    logic [4:0]       waddr_q,    waddr_d;
    logic [31:0]      wdata_q,    wdata_d;
    logic             timeout_q,  timeout_d;
    logic             misal_q,    misal_d;
    logic [CNT_W-1:0] retired_q,  retired_d;

    logic        w_accept;
    logic        w_lsu_accept;
    logic        w_misaligned;
    logic        w_retire;
    logic        w_write;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;

    assign w_accept     = instr_valid_ip && (state_q == C_ST_IDLE);
    assign w_lsu_accept = w_accept && (wb_mux_ip == C_MUX_LSU);
    assign w_misaligned = is_misaligned(lsu_operator_ip, load_byte_offset_ip);

    // ------------------------------------------------------------------------
    // Process 1: state and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= C_ST_IDLE;
            cnt_q      <= 8'd0;
            pend_rd_q  <= 5'd0;
            pend_op_q  <= 3'd0;
            pend_off_q <= 2'd0;
            we_q       <= 1'b0;
            waddr_q    <= 5'd0;
            wdata_q    <= 32'd0;
            timeout_q  <= 1'b0;
            misal_q    <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_rd_q  <= pend_rd_d;
            pend_op_q  <= pend_op_d;
            pend_off_q <= pend_off_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            timeout_q  <= timeout_d;
            misal_q    <= misal_d;
            retired_q  <= retired_d;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: begin
                if (w_lsu_accept && !w_misaligned && !load_data_valid_ip)
                    state_d = C_ST_WAIT;
            end
            C_ST_WAIT: begin
                // Valid data takes priority over an expiring timeout.
                if (load_data_valid_ip || (cnt_q == C_TO_LAST))
                    state_d = C_ST_IDLE;
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: output / datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        w_retire   = 1'b0;
        w_write    = 1'b0;
        w_waddr    = write_reg_addr_ip;
        w_wdata    = wb_alu_result_ip;
        cnt_d      = cnt_q;
        pend_rd_d  = pend_rd_q;
        pend_op_d  = pend_op_q;
        pend_off_d = pend_off_q;
        timeout_d  = timeout_q;
        misal_d    = 1'b0;

        case (state_q)
            C_ST_IDLE: begin
                if (w_accept) begin
                    case (wb_mux_ip)
                        C_MUX_ALU: begin
                            w_retire = 1'b1;
                            w_write  = wb_alu_result_valid_ip;
                            w_wdata  = wb_alu_result_ip;
                        end
                        C_MUX_PC4: begin
                            w_retire = 1'b1;
                            w_write  = 1'b1;
                            w_wdata  = pc_addr_ip + 32'd4;
                        end
                        C_MUX_UIMMD: begin
                            w_retire = 1'b1;
                            w_write  = 1'b1;
                            w_wdata  = uimmd_ip;
                        end
                        default: begin
                            if (w_misaligned) begin
                                misal_d = 1'b1;
                            end else if (load_data_valid_ip) begin
                                w_retire = 1'b1;
                                w_write  = 1'b1;
                                w_wdata  = extract_load(lsu_operator_ip,
                                                        load_byte_offset_ip,
                                                        load_data_ip);
                            end else begin
                                cnt_d      = 8'd0;
                                pend_rd_d  = write_reg_addr_ip;
                                pend_op_d  = lsu_operator_ip;
                                pend_off_d = load_byte_offset_ip;
                            end
                        end
                    endcase
                end
            end
            C_ST_WAIT: begin
                if (load_data_valid_ip) begin
                    w_retire = 1'b1;
                    w_write  = 1'b1;
                    w_waddr  = pend_rd_q;
                    w_wdata  = extract_load(pend_op_q, pend_off_q, load_data_ip);
                end else if (cnt_q == C_TO_LAST) begin
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase

        retired_d = w_retire ? (retired_q + C_CNT_ONE) : retired_q;

        // x0 writes are suppressed; address/data hold when nothing is written.
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (w_write && (w_waddr != 5'd0)) begin
            we_d    = 1'b1;
            waddr_d = w_waddr;
            wdata_d = w_wdata;
        end
    end

    assign stall_op         = (state_q == C_ST_WAIT);
    assign rf_we_op         = we_q;
    assign rf_waddr_op      = waddr_q;
    assign rf_wdata_op      = wdata_q;
    assign load_timeout_op  = timeout_q;
    assign misalign_op      = misal_q;
    assign retired_count_op = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Self-checking bench for writeback_stage. Expected register-file
//            writes are queued when an instruction is driven and compared by a
//            monitor when rf_we_op asserts; each scenario task also checks
//            stall, flags and the retired counter directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    localparam int C_TO    = 4;
    localparam int C_CNT_W = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              instr_valid_ip = 1'b0;
    logic [1:0]        wb_mux_ip = 2'd0;
    logic [31:0]       wb_alu_result_ip = 32'd0;
    logic              wb_alu_result_valid_ip = 1'b0;
    logic [4:0]        write_reg_addr_ip = 5'd0;
    logic [31:0]       pc_addr_ip = 32'd0;
    logic [31:0]       uimmd_ip = 32'd0;
    logic [2:0]        lsu_operator_ip = 3'd0;
    logic [1:0]        load_byte_offset_ip = 2'd0;
    logic [31:0]       load_data_ip = 32'd0;
    logic              load_data_valid_ip = 1'b0;
    logic              rf_we_op;
    logic [4:0]        rf_waddr_op;
    logic [31:0]       rf_wdata_op;
    logic              stall_op;
    logic              load_timeout_op;
    logic              misalign_op;
    logic [C_CNT_W-1:0] retired_count_op;

    writeback_stage #(
        .LOAD_TIMEOUT (C_TO),
        .CNT_W        (C_CNT_W)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .instr_valid_ip         (instr_valid_ip),
        .wb_mux_ip              (wb_mux_ip),
        .wb_alu_result_ip       (wb_alu_result_ip),
        .wb_alu_result_valid_ip (wb_alu_result_valid_ip),
        .write_reg_addr_ip      (write_reg_addr_ip),
        .pc_addr_ip             (pc_addr_ip),
        .uimmd_ip               (uimmd_ip),
        .lsu_operator_ip        (lsu_operator_ip),
        .load_byte_offset_ip    (load_byte_offset_ip),
        .load_data_ip           (load_data_ip),
        .load_data_valid_ip     (load_data_valid_ip),
        .rf_we_op               (rf_we_op),
        .rf_waddr_op            (rf_waddr_op),
        .rf_wdata_op            (rf_wdata_op),
        .stall_op               (stall_op),
        .load_timeout_op        (load_timeout_op),
        .misalign_op            (misalign_op),
        .retired_count_op       (retired_count_op)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_retired = 32'd0;

    // Scoreboard monitor: every write must match the oldest expected write.
    always @(posedge clock) begin
        #1;
        if (rf_we_op === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%h, none required",
                         rf_waddr_op, rf_wdata_op);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (rf_waddr_op !== e.addr || rf_wdata_op !== e.data) begin
                    errors++;
                    $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             rf_waddr_op, rf_wdata_op, e.addr, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        instr_valid_ip         = 1'b0;
        load_data_valid_ip     = 1'b0;
        wb_alu_result_valid_ip = 1'b0;
    endtask

    task automatic drive(input logic [1:0] mux, input logic [4:0] rd,
                         input logic [31:0] val, input logic alu_v,
                         input logic [2:0] op, input logic [1:0] off,
                         input logic [31:0] ld, input logic ld_v);
        instr_valid_ip         = 1'b1;
        wb_mux_ip              = mux;
        write_reg_addr_ip      = rd;
        wb_alu_result_ip       = val;
        wb_alu_result_valid_ip = alu_v;
        pc_addr_ip             = val;
        uimmd_ip               = val;
        lsu_operator_ip        = op;
        load_byte_offset_ip    = off;
        load_data_ip           = ld;
        load_data_valid_ip     = ld_v;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({rf_we_op, rf_waddr_op, rf_wdata_op, stall_op, load_timeout_op,
             misalign_op, retired_count_op} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b addr=%0d data=%h stall=%b to=%b mis=%b cnt=%0d, required all 0",
                     rf_we_op, rf_waddr_op, rf_wdata_op, stall_op, load_timeout_op,
                     misalign_op, retired_count_op);
        end
    endtask

    task automatic test_alu();
        drive(2'd0, 5'd5, 32'h0000_1234, 1'b1, 3'd0, 2'd0, 32'd0, 1'b0);
        push(5'd5, 32'h0000_1234);
        exp_retired++;
        step();
        clear_inputs();
        checks++;
        if (rf_we_op !== 1'b1 || retired_count_op !== exp_retired) begin
            errors++;
            $display("FAIL alu_write: we=%b cnt=%0d, required we=1 cnt=%0d",
                     rf_we_op, retired_count_op, exp_retired);
        end
        step();
        checks++;
        if (rf_we_op !== 1'b0) begin
            errors++;
            $display("FAIL alu_one_cycle: we=%b, required 0", rf_we_op);
        end
    endtask

    task automatic test_load_immediate();
        logic [2:0]  ops  [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0};
        logic [1:0]  offs [6] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1};
        logic [31:0] exps [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                  32'h0000_80FF, 32'h80FF_0000, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            drive(2'd1, 5'(8 + i), 32'd0, 1'b0, ops[i], offs[i], 32'h80FF_0000, 1'b1);
            push(5'(8 + i), exps[i]);
            exp_retired++;
            step();
            checks++;
            if (stall_op !== 1'b0 || rf_we_op !== 1'b1) begin
                errors++;
                $display("FAIL load_immediate[%0d]: stall=%b we=%b, required stall=0 we=1",
                         i, stall_op, rf_we_op);
            end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_load_wait();
        drive(2'd1, 5'd7, 32'd0, 1'b0, 3'd1, 2'd0, 32'hDEAD_BEEF, 1'b0);
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stall_op !== 1'b1 || rf_we_op !== 1'b0) begin
                errors++;
                $display("FAIL load_wait_stall[%0d]: stall=%b we=%b, required stall=1 we=0",
                         i, stall_op, rf_we_op);
            end
            if (i == 2) begin
                load_data_ip       = 32'h0000_8001;
                load_data_valid_ip = 1'b1;
                push(5'd7, 32'hFFFF_8001);
                exp_retired++;
            end
            step();
        end
        load_data_valid_ip = 1'b0;
        checks++;
        if (stall_op !== 1'b0 || rf_we_op !== 1'b1 || retired_count_op !== exp_retired) begin
            errors++;
            $display("FAIL load_wait_done: stall=%b we=%b cnt=%0d, required stall=0 we=1 cnt=%0d",
                     stall_op, rf_we_op, retired_count_op, exp_retired);
        end
    endtask

    task automatic test_timeout();
        drive(2'd1, 5'd9, 32'd0, 1'b0, 3'd2, 2'd0, 32'd0, 1'b0);
        step();
        clear_inputs();
        for (int i = 0; i < C_TO; i++) begin
            checks++;
            if (stall_op !== 1'b1 || load_timeout_op !== 1'b0) begin
                errors++;
                $display("FAIL timeout_stall[%0d]: stall=%b to=%b, required stall=1 to=0",
                         i, stall_op, load_timeout_op);
            end
            step();
        end
        checks++;
        if (stall_op !== 1'b0 || load_timeout_op !== 1'b1 || rf_we_op !== 1'b0 ||
            retired_count_op !== exp_retired) begin
            errors++;
            $display("FAIL timeout_abort: stall=%b to=%b we=%b cnt=%0d, required 0 1 0 %0d",
                     stall_op, load_timeout_op, rf_we_op, retired_count_op, exp_retired);
        end
        drive(2'd0, 5'd10, 32'hCAFE_0001, 1'b1, 3'd0, 2'd0, 32'd0, 1'b0);
        push(5'd10, 32'hCAFE_0001);
        exp_retired++;
        step();
        clear_inputs();
        checks++;
        if (rf_we_op !== 1'b1 || load_timeout_op !== 1'b1 || retired_count_op !== exp_retired) begin
            errors++;
            $display("FAIL timeout_after_alu: we=%b to=%b cnt=%0d, required 1 1 %0d",
                     rf_we_op, load_timeout_op, retired_count_op, exp_retired);
        end
        // Data arriving in the expiry cycle still completes the load.
        drive(2'd1, 5'd11, 32'd0, 1'b0, 3'd2, 2'd0, 32'd0, 1'b0);
        step();
        clear_inputs();
        repeat (C_TO - 1) step();
        load_data_ip       = 32'h1357_9BDF;
        load_data_valid_ip = 1'b1;
        push(5'd11, 32'h1357_9BDF);
        exp_retired++;
        step();
        load_data_valid_ip = 1'b0;
        checks++;
        if (rf_we_op !== 1'b1 || stall_op !== 1'b0 || retired_count_op !== exp_retired) begin
            errors++;
            $display("FAIL timeout_race: we=%b stall=%b cnt=%0d, required 1 0 %0d",
                     rf_we_op, stall_op, retired_count_op, exp_retired);
        end
    endtask

    task automatic test_misalign();
        logic [2:0] ops  [4] = '{3'd2, 3'd1, 3'd5, 3'd3};
        logic [1:0] offs [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            drive(2'd1, 5'd13, 32'd0, 1'b0, ops[i], offs[i], 32'hFFFF_FFFF, 1'b1);
            step();
            clear_inputs();
            checks++;
            if (misalign_op !== 1'b1 || rf_we_op !== 1'b0 || stall_op !== 1'b0 ||
                retired_count_op !== exp_retired) begin
                errors++;
                $display("FAIL misalign[%0d]: mis=%b we=%b stall=%b cnt=%0d, required 1 0 0 %0d",
                         i, misalign_op, rf_we_op, stall_op, retired_count_op, exp_retired);
            end
            step();
            checks++;
            if (misalign_op !== 1'b0) begin
                errors++;
                $display("FAIL misalign_pulse[%0d]: mis=%b, required 0", i, misalign_op);
            end
        end
        drive(2'd2, 5'd1, 32'hFFFF_FFFC, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0);
        push(5'd1, 32'h0000_0000);
        exp_retired++;
        step();
        drive(2'd3, 5'd3, 32'hABCD_E000, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0);
        push(5'd3, 32'hABCD_E000);
        exp_retired++;
        step();
        clear_inputs();
        checks++;
        if (rf_we_op !== 1'b1 || rf_wdata_op !== 32'hABCD_E000 || retired_count_op !== exp_retired) begin
            errors++;
            $display("FAIL uimmd: we=%b data=%h cnt=%0d, required 1 abcde000 %0d",
                     rf_we_op, rf_wdata_op, retired_count_op, exp_retired);
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(2'd0, 5'(20 + i), 32'h0100_0000 + 32'(i), 1'b1, 3'd0, 2'd0, 32'd0, 1'b0);
            push(5'(20 + i), 32'h0100_0000 + 32'(i));
            exp_retired++;
            step();
        end
        clear_inputs();
        checks++;
        if (rf_waddr_op !== 5'd23 || retired_count_op !== exp_retired) begin
            errors++;
            $display("FAIL back_to_back: addr=%0d cnt=%0d, required 23 %0d",
                     rf_waddr_op, retired_count_op, exp_retired);
        end
        step();
    endtask

    task automatic test_reset_mid_wait();
        drive(2'd1, 5'd12, 32'd0, 1'b0, 3'd2, 2'd0, 32'd0, 1'b0);
        step();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_retired = 32'd0;
        checks++;
        if ({rf_we_op, rf_waddr_op, rf_wdata_op, stall_op, load_timeout_op,
             misalign_op, retired_count_op} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: we=%b addr=%0d data=%h stall=%b to=%b mis=%b cnt=%0d, required all 0",
                     rf_we_op, rf_waddr_op, rf_wdata_op, stall_op, load_timeout_op,
                     misalign_op, retired_count_op);
        end
        load_data_ip       = 32'h5555_AAAA;
        load_data_valid_ip = 1'b1;
        step();
        load_data_valid_ip = 1'b0;
        checks++;
        if (rf_we_op !== 1'b0 || retired_count_op !== 32'd0) begin
            errors++;
            $display("FAIL stray_valid: we=%b cnt=%0d, required 0 0", rf_we_op, retired_count_op);
        end
        drive(2'd0, 5'd0, 32'h7777_7777, 1'b1, 3'd0, 2'd0, 32'd0, 1'b0);
        exp_retired++;
        step();
        drive(2'd0, 5'd4, 32'h8888_8888, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0);
        exp_retired++;
        step();
        clear_inputs();
        checks++;
        if (rf_we_op !== 1'b0 || retired_count_op !== exp_retired) begin
            errors++;
            $display("FAIL rd0_and_invalid_alu: we=%b cnt=%0d, required 0 %0d",
                     rf_we_op, retired_count_op, exp_retired);
        end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_alu();
        test_load_immediate();
        test_load_wait();
        test_timeout();
        test_misalign();
        test_back_to_back();
        test_reset_mid_wait();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final (5th) pipeline stage, directly downstream of the memory stage.
- Consumes the memory-stage pipeline-buffer outputs (ALU result, WB mux select, destination register, PC, upper immediate) and the raw load word.
- Extracts and sign/zero-extends load data, selects the write-back source, and drives the register-file write port.
- Stalls the pipeline while a load's data is outstanding, and flags load timeouts and misaligned loads.

Parameters:
- LOAD_TIMEOUT, 16: max cycles spent waiting for load data before abort; legal range 2..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid_ip  in  1  valid instruction presented this cycle.
- wb_mux_ip  in  2  source select: 0=ALU, 1=LSU, 2=PC+4, 3=UIMMD.
- wb_alu_result_ip  in  32  ALU result.
- wb_alu_result_valid_ip  in  1  ALU result valid.
- write_reg_addr_ip  in  5  destination register rd.
- pc_addr_ip  in  32  instruction PC.
- uimmd_ip  in  32  upper immediate (LUI/AUIPC value).
- lsu_operator_ip  in  3  load type: 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU; others illegal.
- load_byte_offset_ip  in  2  address bits [1:0] of the load.
- load_data_ip  in  32  raw aligned memory word.
- load_data_valid_ip  in  1  load_data_ip valid this cycle.
- rf_we_op  out  1  register-file write enable.
- rf_waddr_op  out  5  register-file write address.
- rf_wdata_op  out  32  register-file write data.
- stall_op  out  1  upstream must hold its outputs.
- load_timeout_op  out  1  sticky: a load was aborted by timeout.
- misalign_op  out  1  one-cycle pulse: misaligned load dropped.
- retired_count_op  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (synchronous, wins over all other inputs):
  - all outputs 0;
  - FSM to IDLE;
  - timeout counter 0;
  - a pending load is discarded with no write.
- Accept: an instruction is accepted when instr_valid_ip=1 and stall_op=0.
- stall_op is combinational: 1 iff state==WAIT_LOAD.
- Non-LSU instruction: registered result, 1-cycle latency.
  - rf_we_op=1 in the cycle after accept, for exactly one cycle.
  - Data: ALU → wb_alu_result_ip; PC+4 → pc_addr_ip+4 (mod 2^32); UIMMD → uimmd_ip.
  - ALU source with wb_alu_result_valid_ip=0: no write, still retired.
- rd==0: rf_we_op stays 0; instruction still counts as retired.
- Load extraction (byte lane = load_byte_offset_ip):
  - LB/LBU: lane byte [8*off+7 : 8*off], sign-/zero-extended.
  - LH/LHU: halfword at off (0 or 2), sign-/zero-extended.
  - LW: full word.
- Misalignment: LH/LHU with off[0]=1, LW with off≠0, or an illegal operator.
  - Checked at accept.
  - misalign_op pulses in the next cycle.
  - No write, no retire, no wait.
- FSM states: IDLE, WAIT_LOAD.
  - IDLE, LSU accept, aligned, load_data_valid_ip=1 → write next cycle; stay IDLE.
  - IDLE, LSU accept, aligned, load_data_valid_ip=0 → WAIT_LOAD. Latch rd, operator and offset; counter=0.
  - WAIT_LOAD, load_data_valid_ip=1 → IDLE. Write extracted data next cycle and retire.
  - WAIT_LOAD, no valid → counter+1. When counter reaches LOAD_TIMEOUT-1 without valid: load_timeout_op=1 (sticky until reset), → IDLE, no write, no retire.
  - Valid arriving in the same cycle as the timeout expiry: valid wins, load completes normally.
  - load_data_valid_ip while IDLE with no LSU accept: ignored.
- retired_count_op:
  - +1 in the cycle rf_we_op would assert for every non-dropped instruction, including rd==0.
  - Wraps at 2^CNT_W.
- rf_waddr_op/rf_wdata_op hold their last values when rf_we_op=0.

Test Plan:
1. ALU op, rd=5, wb_alu_result_ip=0x0000_1234, valid=1 → next cycle rf_we_op=1, rf_waddr_op=5, rf_wdata_op=0x0000_1234; retired_count_op=1.
2. LB off=3, load_data_ip=0x80FF_0000 valid same cycle → rf_wdata_op=0xFFFF_FF80. Same case with LBU → 0x0000_0080. Both: no stall.
3. LH off=0, data valid 3 cycles after accept with 0x0000_8001 → stall_op=1 for 3 cycles, then rf_wdata_op=0xFFFF_8001 one cycle after valid.
4. LW, LOAD_TIMEOUT=4, data never valid → stall for 4 cycles, then load_timeout_op=1 (stays 1), no rf_we_op, retired_count_op unchanged, next ALU op accepted.
5. LW off=2 → misalign_op=1 for one cycle, rf_we_op=0, no stall. PC+4 op, pc=0xFFFF_FFFC, rd=1 → rf_wdata_op=0x0000_0000.
6. Reset asserted mid-WAIT_LOAD → next cycle stall_op=0, all outputs 0; a later load_data_valid_ip produces no write. ALU op with rd=0 → rf_we_op=0, count+1.
